// File: rtl/boss_ctrl_if.sv
// Boss controller bus: game-side inputs and renderer-facing outputs.
interface boss_ctrl_if;
  logic [3:0] state;
  logic       tick;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic       hit;
  logic [8:0] boss_x;
  logic [8:0] boss_y;
  logic [3:0] boss_state;
  logic [2:0] boss_hp;
  logic       boss_dead;

  modport master (
    output state, tick, player_x, player_y, hit,
    input  boss_x, boss_y, boss_state, boss_hp, boss_dead
  );

  modport slave (
    input  state, tick, player_x, player_y, hit,
    output boss_x, boss_y, boss_state, boss_hp, boss_dead
  );
endinterface

// File: rtl/boss_ctrl.sv
// Boss motion/animation controller: chases the player in the boss stage,
// tracks hit points, and cycles idle frames on the staff/fail screens.
//
// state | meaning
// IDLE  | parked at spawn; animates frames 0-3 on STAFF/FAIL screens
// CHASE | steps toward the player every STEP_DIV ticks, walk frames 0-3
// HURT  | invulnerable, frames 4/5 flash for HIT_TICKS ticks
// DEAD  | frozen on frame 6 until the game leaves the boss stage
module boss_ctrl #(
  parameter logic [3:0] STAGE3    = 4'd6,
  parameter logic [3:0] FAIL      = 4'd8,
  parameter logic [3:0] STAFF     = 4'd1,
  parameter logic [8:0] X_MAX     = 9'd310,
  parameter logic [8:0] Y_MAX     = 9'd230,
  parameter logic [8:0] START_X   = 9'd150,
  parameter logic [8:0] START_Y   = 9'd20,
  parameter int         STEP_DIV  = 4,
  parameter int         ANIM_DIV  = 8,
  parameter logic [2:0] HP_INIT   = 3'd5,
  parameter int         HIT_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  boss_ctrl_if.slave  bus
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int AW = $clog2(ANIM_DIV);
  localparam int HW = $clog2(HIT_TICKS);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [HW-1:0] HURT_LAST = HW'(HIT_TICKS - 1);
  localparam logic [3:0] FR_HURT_A = 4'd4;
  localparam logic [3:0] FR_HURT_B = 4'd5;
  localparam logic [3:0] FR_DEAD   = 4'd6;

  typedef enum logic [1:0] {IDLE, CHASE, HURT, DEAD} mode_t;

  mode_t          mode_q, mode_d;
  logic [8:0]     x_q, x_d, y_q, y_d;
  logic [3:0]     frame_q, frame_d;
  logic [2:0]     hp_q, hp_d;
  logic           dead_q, dead_d;
  logic [SW-1:0]  step_q, step_d;
  logic [AW-1:0]  anim_q, anim_d;
  logic [HW-1:0]  hurt_q, hurt_d;

  logic           anim_wrap;
  logic [AW-1:0]  anim_next;
  logic [3:0]     frame_walk;
  logic           anim_screen;

  // One pixel toward the target, computed 10 bits wide so +1 at 511 cannot wrap.
  function automatic logic [8:0] step_axis(input logic [8:0] pos,
                                           input logic [8:0] tgt,
                                           input logic [8:0] lim);
    logic [9:0] nxt;
    nxt = {1'b0, pos};
    if (pos < tgt)      nxt = nxt + 10'd1;
    else if (pos > tgt) nxt = nxt - 10'd1;
    if (nxt > {1'b0, lim}) nxt = {1'b0, lim};
    return nxt[8:0];
  endfunction

  // Shared walk/idle animation divider: frames 0-3 advance every ANIM_DIV ticks.
  always_comb begin
    anim_wrap   = (anim_q == ANIM_LAST);
    anim_next   = anim_wrap ? '0 : anim_q + AW'(1);
    frame_walk  = anim_wrap ? {2'b00, frame_q[1:0] + 2'd1} : frame_q;
    anim_screen = (bus.state == STAFF) || (bus.state == FAIL);
  end

  // Next-state and next-output logic; leaving the boss stage overrides everything.
  always_comb begin
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    hp_d    = hp_q;
    dead_d  = dead_q;
    step_d  = step_q;
    anim_d  = anim_q;
    hurt_d  = hurt_q;
    if (bus.state != STAGE3) begin
      mode_d = IDLE;
      x_d    = START_X;
      y_d    = START_Y;
      hp_d   = HP_INIT;
      dead_d = 1'b0;
      step_d = '0;
      hurt_d = '0;
      if (mode_q != IDLE) begin
        // Frames 4-6 are meaningless on the idle cycle, so restart from 0.
        frame_d = '0;
        anim_d  = '0;
      end else if (anim_screen) begin
        if (bus.tick) begin
          anim_d  = anim_next;
          frame_d = frame_walk;
        end
      end else begin
        frame_d = '0;
        anim_d  = '0;
      end
    end else begin
      unique case (mode_q)
        IDLE: begin
          mode_d  = CHASE;
          step_d  = '0;
          anim_d  = '0;
          frame_d = '0;
        end
        CHASE: begin
          if (bus.hit) begin
            hp_d = hp_q - 3'd1;
            if (hp_q == 3'd1) begin
              mode_d  = DEAD;
              frame_d = FR_DEAD;
              dead_d  = 1'b1;
            end else begin
              mode_d  = HURT;
              hurt_d  = '0;
              frame_d = FR_HURT_A;
            end
          end else if (bus.tick) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              x_d    = step_axis(x_q, bus.player_x, X_MAX);
              y_d    = step_axis(y_q, bus.player_y, Y_MAX);
            end else begin
              step_d = step_q + SW'(1);
            end
            anim_d  = anim_next;
            frame_d = frame_walk;
          end
        end
        HURT: begin
          if (bus.tick) begin
            if (hurt_q == HURT_LAST) begin
              mode_d  = CHASE;
              frame_d = '0;
              step_d  = '0;
              anim_d  = '0;
            end else begin
              hurt_d  = hurt_q + HW'(1);
              frame_d = (frame_q == FR_HURT_A) ? FR_HURT_B : FR_HURT_A;
            end
          end
        end
        DEAD: begin
          frame_d = FR_DEAD;
          dead_d  = 1'b1;
        end
        default: mode_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset to the spawn values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= IDLE;
      x_q     <= START_X;
      y_q     <= START_Y;
      frame_q <= '0;
      hp_q    <= HP_INIT;
      dead_q  <= 1'b0;
      step_q  <= '0;
      anim_q  <= '0;
      hurt_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      hp_q    <= hp_d;
      dead_q  <= dead_d;
      step_q  <= step_d;
      anim_q  <= anim_d;
      hurt_q  <= hurt_d;
    end
  end

  assign bus.boss_x     = x_q;
  assign bus.boss_y     = y_q;
  assign bus.boss_state = frame_q;
  assign bus.boss_hp    = hp_q;
  assign bus.boss_dead  = dead_q;

endmodule

// File: tb/tb_boss_ctrl.sv
// Scoreboard bench for boss_ctrl: a behavioural model predicts the outputs
// after every clock; a monitor compares them one cycle later.
module tb_boss_ctrl;

  localparam int M_IDLE = 0, M_CHASE = 1, M_HURT = 2, M_DEAD = 3;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [3:0] fr;
    logic [2:0] hp;
    logic       dead;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boss_ctrl_if bus ();

  boss_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model state, in plain game terms.
  int m_mode, bx, by, fr, hp, dead, steps, anim, hurt;

  function automatic int toward(input int b, input int p, input int lim);
    int n;
    n = b;
    if (b < p) n = b + 1;
    else if (b > p) n = b - 1;
    if (n > lim) n = lim;
    if (n < 0) n = 0;
    return n;
  endfunction

  task automatic anim_tick();
    if (anim == 7) begin
      anim = 0;
      fr = (fr + 1) % 4;
    end else begin
      anim++;
    end
  endtask

  task automatic spawn();
    m_mode = M_IDLE; bx = 150; by = 20; fr = 0; hp = 5; dead = 0;
    steps = 0; anim = 0; hurt = 0;
  endtask

  task automatic model_step(input bit r, input int st, input bit tk,
                            input int px, input int py, input bit ht);
    if (r) begin
      spawn();
    end else if (st != 6) begin
      if (m_mode != M_IDLE) begin
        spawn();
      end else if (st == 1 || st == 8) begin
        if (tk) anim_tick();
      end else begin
        anim = 0; fr = 0;
      end
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_mode = M_CHASE; steps = 0; anim = 0; fr = 0;
        end
        M_CHASE: begin
          if (ht) begin
            hp = hp - 1;
            if (hp == 0) begin
              m_mode = M_DEAD; fr = 6; dead = 1;
            end else begin
              m_mode = M_HURT; hurt = 0; fr = 4;
            end
          end else if (tk) begin
            steps++;
            if (steps == 4) begin
              steps = 0;
              bx = toward(bx, px, 310);
              by = toward(by, py, 230);
            end
            anim_tick();
          end
        end
        M_HURT: begin
          if (tk) begin
            hurt++;
            if (hurt == 16) begin
              m_mode = M_CHASE; fr = 0; steps = 0; anim = 0;
            end else begin
              fr = (fr == 4) ? 5 : 4;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic drive(input bit r, input int st, input bit tk,
                       input int px, input int py, input bit ht);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.state    = 4'(st);
    bus.tick     = tk;
    bus.player_x = 9'(px);
    bus.player_y = 9'(py);
    bus.hit      = ht;
    model_step(r, st, tk, px, py, ht);
    e.x = 9'(bx); e.y = 9'(by); e.fr = 4'(fr); e.hp = 3'(hp); e.dead = dead[0];
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (bus.boss_x !== e.x || bus.boss_y !== e.y || bus.boss_state !== e.fr ||
            bus.boss_hp !== e.hp || bus.boss_dead !== e.dead) begin
          fails++;
          $display("FAIL outputs t=%0t got x=%0d y=%0d st=%0d hp=%0d dead=%0d want x=%0d y=%0d st=%0d hp=%0d dead=%0d",
                   $time, bus.boss_x, bus.boss_y, bus.boss_state, bus.boss_hp, bus.boss_dead,
                   e.x, e.y, e.fr, e.hp, e.dead);
        end
      end
    end
  end

  initial begin
    int st, px, py;
    rst = 1'b1;
    bus.state = '0; bus.tick = 1'b0; bus.player_x = '0; bus.player_y = '0; bus.hit = 1'b0;
    spawn();

    repeat (3) drive(1, 0, 0, 0, 0, 0);
    repeat (6) drive(0, 0, 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));

    // Enter the stage, chase toward (100,20) for 32 ticks with random gaps.
    drive(0, 6, 0, 100, 20, 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 6, 1, 100, 20, 0);
      repeat ($urandom_range(0, 2)) drive(0, 6, 0, 100, 20, 0);
    end

    // Player beyond the field: boss ends parked at (310,230).
    repeat (950) drive(0, 6, 1, 400, 240, 0);

    // Hit with a tick, then hits during the invulnerable window.
    drive(0, 6, 1, 400, 240, 1);
    for (int i = 0; i < 16; i++) drive(0, 6, 1, 400, 240, 1'($urandom_range(0, 1)));

    // Remaining hits spaced past recovery until dead.
    for (int i = 0; i < 4; i++) begin
      drive(0, 6, 0, 400, 240, 1);
      repeat (20) drive(0, 6, 1, 400, 240, 0);
    end
    repeat (12) drive(0, 6, 1'($urandom_range(0, 1)), $urandom_range(0, 511),
                      $urandom_range(0, 511), 1'($urandom_range(0, 1)));

    // Fail screen: back to spawn, frames cycle every 8 ticks.
    repeat (40) drive(0, 8, 1, 0, 0, 0);

    // Leave the stage mid-hurt.
    drive(0, 6, 0, 100, 20, 0);
    drive(0, 6, 1, 100, 20, 1);
    repeat (3) drive(0, 6, 1, 100, 20, 0);
    drive(0, 1, 0, 100, 20, 0);
    drive(0, 1, 1, 100, 20, 0);

    // Reset while chasing at (142,20).
    drive(0, 6, 0, 100, 20, 0);
    repeat (32) drive(0, 6, 1, 100, 20, 0);
    drive(1, 6, 1, 100, 20, 1);
    drive(0, 6, 0, 100, 20, 0);

    // Random soak with sticky game state and occasional resets.
    st = 6; px = 150; py = 20;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 5))
          0: st = 1;
          1: st = 8;
          2: st = $urandom_range(0, 15);
          default: st = 6;
        endcase
      end
      if ($urandom_range(0, 63) == 0) begin
        px = $urandom_range(0, 511);
        py = $urandom_range(0, 511);
      end
      drive(1'($urandom_range(0, 499) == 0), st, 1'($urandom_range(0, 1)),
            px, py, 1'($urandom_range(0, 39) == 0));
    end

    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
